muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative RV32M execution unit; consumer end of the Control alu_ctl interface for codes 00010..01001.
//  Accepts one mul/mulh/mulsu/mulu/div/divu/rem/remu operation per start pulse.
//  Returns the result with a single-cycle done pulse. Sits beside the ALU; the pipeline stalls while busy.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk      in   1     single clock, rising edge
//  rst_n    in   1     asynchronous, active-low reset
//  start    in   1     request; sampled only when state==IDLE
//  alu_ctl  in   5     op code (00010 mul, 00011 mulh, 00100 mulsu, 00101 mulu, 00110 div, 00111 divu, 01000 rem, 01001 remu)
//  op_a     in   XLEN  rs1 value (multiplicand/dividend)
//  op_b     in   XLEN  rs2 value (multiplier/divisor)
//  flush    in   1     abort current operation (branch/jump kill)
//  busy     out  1     state!=IDLE
//  done     out  1     one-cycle pulse, result valid
//  result   out  XLEN  registered result, held until next done
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE, busy=0, done=0, result=0, counter=0, operand regs=0.
//  FSM: IDLE -> CALC -> DONE -> IDLE. IDLE -> DONE directly for special divide cases.
//  Accept: start=1 in IDLE with alu_ctl in 00010..01001 at cycle T.
//   - Latch op_a, op_b, alu_ctl, operand signs.
//   - Ops outside that range, or start outside IDLE: ignored, no state change.
//  Signedness:
//   - mul/mulh/div/rem: a and b signed.
//   - mulsu: a signed, b unsigned.
//   - mulu/divu/remu: both unsigned.
//   Datapath works on magnitudes; sign fix-up is applied on entry to DONE.
//  Multiply: shift-add, one multiplier bit per cycle, 2*XLEN product register.
//   - mul returns low XLEN bits; mulh/mulsu/mulu return high XLEN bits of the signed-corrected product.
//  Divide: restoring, one quotient bit per cycle.
//   - Quotient sign = sa^sb; remainder sign = sa (truncating, RISC-V semantics).
//  Latency, normal op:
//   - CALC spans T+1..T+XLEN (counter 0..XLEN-1).
//   - DONE at T+XLEN+1: done=1, result updated the same cycle.
//   - IDLE at T+XLEN+2; a new start is accepted at T+XLEN+2.
//  Special divide cases (no iteration; DONE at T+1, done=1 at T+1):
//   - b==0: div/divu -> all ones; rem/remu -> op_a.
//   - Signed overflow (a=-2^(XLEN-1), b=-1) for div -> a; for rem -> 0.
//  Flush:
//   - In CALC or DONE: next state IDLE, done forced 0 that cycle and thereafter, result unchanged.
//   - flush together with start in IDLE: start ignored.
//  busy=1 in CALC and DONE; done=1 only in DONE and never two cycles in a row.
//  Reset asserted mid-operation: immediate return to reset values; no done pulse.
// TESTING
//  1. mul a=7, b=0xFFFFFFFD, start@T -> busy T+1..T+33, done@T+33, result=0xFFFFFFEB.
//  2. mulh 0x80000000*0x80000000 -> 0x40000000; mulu 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE;
//     mulsu 0xFFFFFFFF*2 -> 0xFFFFFFFF.
//  3. div 0xFFFFFFF9/2 -> 0xFFFFFFFD; rem same operands -> 0xFFFFFFFF; divu 100/7 -> 14; remu -> 2.
//  4. divu 5/0 -> done@T+1, 0xFFFFFFFF; remu 5/0 -> 5;
//     div 0x80000000/0xFFFFFFFF -> 0x80000000; rem -> 0.
//  5. Flush @T+10 of a mul -> busy=0 @T+11, no done, result keeps prior value;
//     start@T+11 -> done@T+44.
//  6. rst_n low @T+5 mid-divide -> busy/done/result=0 asynchronously;
//     start with alu_ctl=00000 -> busy stays 0.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle on operand magnitudes, with sign fix-up on entry to DONE.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [4:0]      alu_ctl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0]   LAST    = CW'(XLEN - 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [4:0] OP_MUL   = 5'b00010;
  localparam logic [4:0] OP_MULH  = 5'b00011;
  localparam logic [4:0] OP_MULSU = 5'b00100;
  localparam logic [4:0] OP_MULU  = 5'b00101;
  localparam logic [4:0] OP_DIV   = 5'b00110;
  localparam logic [4:0] OP_DIVU  = 5'b00111;
  localparam logic [4:0] OP_REM   = 5'b01000;
  localparam logic [4:0] OP_REMU  = 5'b01001;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state, state_n;
  logic [4:0]      op_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] opnd_q;       // multiplicand or divisor magnitude
  logic [XLEN-1:0] hi_q, lo_q;   // product hi/lo, or remainder/quotient
  logic [XLEN-1:0] result_q;
  logic [CW-1:0]   cnt_q;

  // Request decode: signedness, magnitudes and the no-iteration divide cases.
  logic            valid_op, is_div, signed_a, signed_b, sa_in, sb_in;
  logic            accept, special;
  logic [XLEN-1:0] mag_a, mag_b, special_res;

  always_comb begin
    valid_op = (alu_ctl >= OP_MUL) && (alu_ctl <= OP_REMU);
    is_div   = valid_op && (alu_ctl >= OP_DIV);
    signed_a = alu_ctl inside {OP_MUL, OP_MULH, OP_MULSU, OP_DIV, OP_REM};
    signed_b = alu_ctl inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
    sa_in    = signed_a && op_a[XLEN-1];
    sb_in    = signed_b && op_b[XLEN-1];
    mag_a    = sa_in ? -op_a : op_a;
    mag_b    = sb_in ? -op_b : op_b;
    accept   = (state == IDLE) && start && !flush && valid_op;
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    special     = 1'b0;
    special_res = '0;
    if (is_div && (op_b == '0)) begin
      special     = 1'b1;
      special_res = (alu_ctl == OP_DIV || alu_ctl == OP_DIVU) ? '1 : op_a;
    end else if (is_div && signed_a && (op_a == MIN_NEG) && (op_b == '1)) begin
      special     = 1'b1;
      special_res = (alu_ctl == OP_DIV) ? op_a : '0;
    end
  end

  // One iteration step plus the signed fix-up of its outcome.
  logic [XLEN:0]     sum, shifted, diff;
  logic [XLEN-1:0]   hi_n, lo_n, quo, rem, fix_res;
  logic [2*XLEN-1:0] prod;

  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (op_q >= OP_DIV) begin
      hi_n = diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
    prod = {hi_n, lo_n};
    if (sa_q ^ sb_q) prod = -prod;
    quo = (sa_q ^ sb_q) ? -lo_n : lo_n;
    rem = sa_q ? -hi_n : hi_n;
    case (op_q)
      OP_MUL:           fix_res = prod[XLEN-1:0];
      OP_DIV, OP_DIVU:  fix_res = quo;
      OP_REM, OP_REMU:  fix_res = rem;
      default:          fix_res = prod[2*XLEN-1:XLEN];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    busy    = (state != IDLE);
    done    = (state == DONE) && !flush;
    case (state)
      IDLE: if (accept) state_n = special ? DONE : CALC;
      CALC: begin
        if (flush)               state_n = IDLE;
        else if (cnt_q == LAST)  state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (accept) begin
      op_q   <= alu_ctl;
      sa_q   <= sa_in;
      sb_q   <= sb_in;
      opnd_q <= is_div ? mag_b : mag_a;
      lo_q   <= is_div ? mag_a : mag_b;
      hi_q   <= '0;
      cnt_q  <= '0;
      if (special) result_q <= special_res;
    end else if (state == CALC && !flush) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + CW'(1);
      if (cnt_q == LAST) result_q <= fix_res;
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: stimulus pushes expected result and done cycle,
// a negedge monitor pops and compares whenever done is presented.
module tb_muldiv_unit;

  localparam logic [4:0] OP_MUL   = 5'b00010;
  localparam logic [4:0] OP_MULH  = 5'b00011;
  localparam logic [4:0] OP_MULSU = 5'b00100;
  localparam logic [4:0] OP_MULU  = 5'b00101;
  localparam logic [4:0] OP_DIV   = 5'b00110;
  localparam logic [4:0] OP_DIVU  = 5'b00111;
  localparam logic [4:0] OP_REM   = 5'b01000;
  localparam logic [4:0] OP_REMU  = 5'b01001;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  logic [4:0]  alu_ctl = '0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        busy, done;
  logic [31:0] result;

  int          cyc = 0, checks = 0, errors = 0;
  logic [31:0] last_res = '0;

  typedef struct {
    string       name;
    logic [31:0] value;
    int          cyc;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    string       name;
    logic [4:0]  op;
    logic [31:0] a, b, exp;
    int          lat;
  } vec_t;

  vec_t vecs [19] = '{
    '{"mulh_min_min",   OP_MULH,  32'h80000000, 32'h80000000, 32'h40000000, 33},
    '{"mulu_max_max",   OP_MULU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33},
    '{"mulsu_neg1_2",   OP_MULSU, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33},
    '{"mulsu_2_big",    OP_MULSU, 32'h00000002, 32'hFFFFFFFF, 32'h00000001, 33},
    '{"mulh_7_neg3",    OP_MULH,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 33},
    '{"mul_shift",      OP_MUL,   32'h12345678, 32'h00000010, 32'h23456780, 33},
    '{"div_neg7_2",     OP_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 33},
    '{"rem_neg7_2",     OP_REM,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 33},
    '{"divu_100_7",     OP_DIVU,  32'd100,      32'd7,        32'd14,       33},
    '{"remu_100_7",     OP_REMU,  32'd100,      32'd7,        32'd2,        33},
    '{"div_min_1",      OP_DIV,   32'h80000000, 32'h00000001, 32'h80000000, 33},
    '{"rem_min_3",      OP_REM,   32'h80000000, 32'h00000003, 32'hFFFFFFFE, 33},
    '{"remu_max_16",    OP_REMU,  32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 33},
    '{"divu_5_0",       OP_DIVU,  32'd5,        32'd0,        32'hFFFFFFFF, 1},
    '{"remu_5_0",       OP_REMU,  32'd5,        32'd0,        32'd5,        1},
    '{"div_ovf",        OP_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1},
    '{"rem_ovf",        OP_REM,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1},
    '{"div_7_0",        OP_DIV,   32'h00000007, 32'h00000000, 32'hFFFFFFFF, 1},
    '{"rem_neg7_0",     OP_REM,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 1}
  };

  muldiv_unit #(.XLEN(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .alu_ctl (alu_ctl),
    .op_a    (op_a),
    .op_b    (op_b),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Called on a negedge; start is held for exactly one cycle.
  task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat,
                       input bit push);
    start   = 1'b1;
    alu_ctl = op;
    op_a    = a;
    op_b    = b;
    if (push) begin
      sb_q.push_back('{name, exp, cyc + lat});
      last_res = exp;
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (!busy) return;
      @(negedge clk);
    end
    check("idle_timeout", {31'b0, busy}, 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && done) begin
      if (sb_q.size() == 0) begin
        check("unexpected_done", {31'b0, done}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        check(e.name, result, e.value);
        check({e.name, "_cycle"}, cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    int t;
    repeat (2) @(negedge clk);
    check("rst_busy",   {31'b0, busy}, 32'd0);
    check("rst_done",   {31'b0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic mul with latency probes and a start that arrives while busy.
    t = cyc;
    issue("mul_7_neg3", OP_MUL, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1);
    check("busy_first", {31'b0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    issue("", OP_DIVU, 32'd100, 32'd7, 32'd0, 0, 1'b0);
    while (cyc < t + 33) @(negedge clk);
    check("busy_in_done", {31'b0, busy}, 32'd1);
    @(negedge clk);
    check("busy_after_done", {31'b0, busy}, 32'd0);

    // Back-to-back table: each start lands on the first idle cycle.
    foreach (vecs[i]) begin
      issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, 1'b1);
      wait_idle();
    end

    // Flush together with start in IDLE: request dropped.
    start = 1'b1; flush = 1'b1; alu_ctl = OP_MUL; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_idle", {31'b0, busy}, 32'd0);

    // Flush mid-multiply: no done, result held, restart accepted next cycle.
    t = cyc;
    issue("", OP_MUL, 32'd3, 32'd5, 32'd0, 0, 1'b0);
    while (cyc < t + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_result_held", result, last_res);
    issue("mul_after_flush", OP_MUL, 32'd3, 32'd5, 32'd15, 33, 1'b1);
    wait_idle();

    // Asynchronous reset in the middle of a divide.
    t = cyc;
    issue("", OP_DIV, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
    while (cyc < t + 5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy",   {31'b0, busy}, 32'd0);
    check("arst_done",   {31'b0, done}, 32'd0);
    check("arst_result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Codes outside the mul/div range are ignored.
    issue("", 5'b00000, 32'd1, 32'd1, 32'd0, 0, 1'b0);
    check("bad_op_0", {31'b0, busy}, 32'd0);
    issue("", 5'b01010, 32'd1, 32'd1, 32'd0, 0, 1'b0);
    check("bad_op_10", {31'b0, busy}, 32'd0);

    issue("mul_after_reset", OP_MUL, 32'd3, 32'd4, 32'd12, 33, 1'b1);
    wait_idle();
    repeat (3) @(negedge clk);
    check("scoreboard_empty", sb_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
